// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP multiplier arbiter.
// Holds the FSM state encoding and requester-index width helper.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_mul_if.sv
// Start/done handshake towards the shared FP multiplier.
// master: arbiter side, slave: multiplier side.
interface fp_mul_if;

  logic        mul_ready;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic [31:0] mul_res;
  logic        mul_done;

  modport master (
    output mul_ready,
    output mul_op1,
    output mul_op2,
    input  mul_res,
    input  mul_done
  );

  modport slave (
    input  mul_ready,
    input  mul_op1,
    input  mul_op2,
    output mul_res,
    output mul_done
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit
// at or above ptr_i, wrapping around.
module rr_picker
  import fp_mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [IW-1:0]    idx_o,
  output logic             vld_o
);

  localparam logic [IW:0] NW = (IW+1)'(N_REQ);

  logic [IW:0] k;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    k     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = {1'b0, ptr_i} + (IW+1)'(i);
      if (k >= NW) k = k - NW;
      if (req_i[k[IW-1:0]]) begin
        idx_o = k[IW-1:0];
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP multiplier between
// N_REQ requesters, with a watchdog on the done pulse.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  op1_i,
  input  logic [32*N_REQ-1:0]  op2_i,
  output logic [N_REQ-1:0]     ack,
  output logic [31:0]          res_o,
  output logic                 err,
  output logic                 busy,
  fp_mul_if.master             mul
);

  localparam int IW = idx_w(N_REQ);
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

  state_e state_q, state_d;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       cnt_inc;
  logic             flag_q, flag_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [31:0]      res_q, res_d;
  logic             rdy_q, rdy_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [IW-1:0]    pick_idx;
  logic             pick_vld;

  logic [N_REQ-1:0][31:0] op1_a;
  logic [N_REQ-1:0][31:0] op2_a;

  assign op1_a   = op1_i;
  assign op2_a   = op2_i;
  assign cnt_inc = cnt_q + 8'd1;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // Outputs are registered, so pulses are set on entry
  // to the state in which they must be visible.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    rdy_d   = 1'b0;
    ack_d   = '0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          op1_d   = op1_a[pick_idx];
          op2_d   = op2_a[pick_idx];
          rdy_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul.mul_done) begin
          res_d        = mul.mul_res;
          ack_d[win_q] = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            res_d        = QNAN;
            flag_d       = 1'b1;
            err_d        = 1'b1;
            ack_d[win_q] = 1'b1;
            state_d      = S_RESP;
          end
        end
      end
      S_RESP: begin
        ptr_d   = (win_q == LAST) ? '0 : win_q + 1'b1;
        flag_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ack           = ack_q;
  assign res_o         = res_q;
  assign err           = err_q;
  assign busy          = busy_q;
  assign mul.mul_ready = rdy_q;
  assign mul.mul_op1   = op1_q;
  assign mul.mul_op2   = op2_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: transaction-timeline reference
// model, directed scenarios, then randomized traffic.
module tb_fp_mul_arbiter;
  import fp_mul_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 31;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [32*N-1:0]   op1_i;
  logic [32*N-1:0]   op2_i;
  logic [N-1:0]      ack;
  logic [31:0]       res_o;
  logic              err;
  logic              busy;

  fp_mul_if mif ();

  fp_mul_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op1_i (op1_i),
    .op2_i (op2_i),
    .ack   (ack),
    .res_o (res_o),
    .err   (err),
    .busy  (busy),
    .mul   (mif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // stimulus
  logic [N-1:0] s_req = '0;
  logic [31:0]  s_op1 [N];
  logic [31:0]  s_op2 [N];
  logic         s_rst = 1'b1;
  int           s_lat = 1;
  bit           spur_en = 1'b0;
  bit           drop_on_ack [N];

  // model: one transaction timeline
  bit          m_act = 1'b0;
  bit          m_to  = 1'b0;
  int          m_g = 0;
  int          m_r = 0;
  int          m_win = 0;
  int          m_ptr = 0;
  int          m_acked = -1;
  logic [31:0] m_res = '0;
  logic [31:0] m_pres = '0;
  logic [31:0] m_op1 = '0;
  logic [31:0] m_op2 = '0;

  // observation logs for literal checks
  int          ack_q [$];
  logic [31:0] ackres_q [$];
  bit          ackerr_q [$];
  int          ackcyc_q [$];
  int          rdy_n = 0;
  int          rdy_cyc = 0;
  logic [31:0] rdy_op1 = '0;

  function automatic logic [31:0] fpmul(input logic [31:0] a,
                                        input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], 8'(e), m};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)),
            8'($urandom_range(110, 144)),
            8'($urandom_range(0, 255)), 15'b0};
  endfunction

  function automatic int ack_at(input int i);
    return (i < ack_q.size()) ? ack_q[i] : -1;
  endfunction

  function automatic logic [31:0] res_at(input int i);
    return (i < ackres_q.size()) ? ackres_q[i] : 32'hDEADBEEF;
  endfunction

  function automatic int err_at(input int i);
    return (i < ackerr_q.size()) ? int'(ackerr_q[i]) : -1;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h",
               nm, cyc, got, exp);
    end
  endtask

  task automatic check();
    logic [N-1:0] e_ack;
    bit           at_r;
    at_r  = m_act && (cyc == m_r);
    e_ack = '0;
    if (at_r) e_ack[m_win] = 1'b1;
    cmp("ack", 32'(ack), 32'(e_ack));
    cmp("err", 32'(err), 32'(at_r && m_to));
    cmp("busy", 32'(busy), 32'(m_act && cyc > m_g));
    cmp("mul_ready", 32'(mif.mul_ready),
        32'(m_act && cyc == m_g + 1));
    cmp("mul_op1", mif.mul_op1, m_op1);
    cmp("mul_op2", mif.mul_op2, m_op2);
    cmp("res_o", res_o, m_res);
    if (ack != '0) begin
      for (int k = 0; k < N; k++)
        if (ack[k]) ack_q.push_back(k);
      ackres_q.push_back(res_o);
      ackerr_q.push_back(err);
      ackcyc_q.push_back(cyc);
    end
    if (mif.mul_ready) begin
      rdy_n++;
      rdy_cyc = cyc;
      rdy_op1 = mif.mul_op1;
    end
  endtask

  task automatic step();
    bit in_wait;
    bit real_done;
    int k;
    int L;
    if (m_act && cyc > m_r) m_act = 1'b0;
    if (m_act && cyc == m_r) m_res = m_to ? QNAN : m_pres;
    if (cyc > 0) check();
    rst = s_rst;
    req = s_req;
    for (int i = 0; i < N; i++) begin
      op1_i[32*i +: 32] = s_op1[i];
      op2_i[32*i +: 32] = s_op2[i];
    end
    in_wait   = m_act && cyc >= m_g + 2 && cyc <= m_r - 1;
    real_done = m_act && !m_to && cyc == m_r - 1;
    mif.mul_done = real_done ||
      (!in_wait && spur_en && $urandom_range(0, 3) == 0);
    mif.mul_res  = real_done ? m_pres : $urandom();
    m_acked = -1;
    if (s_rst) begin
      m_act = 1'b0;
      m_ptr = 0;
      m_res = '0;
      m_op1 = '0;
      m_op2 = '0;
    end else if (m_act && cyc == m_r) begin
      m_ptr   = (m_win + 1) % N;
      m_acked = m_win;
    end else if (!m_act && s_req != '0) begin
      k = -1;
      for (int i = N - 1; i >= 0; i--)
        if (s_req[(m_ptr + i) % N]) k = (m_ptr + i) % N;
      m_win  = k;
      m_g    = cyc;
      m_op1  = s_op1[k];
      m_op2  = s_op2[k];
      m_to   = (s_lat <= 0) || (s_lat > TMO);
      L      = m_to ? TMO : s_lat;
      m_r    = cyc + L + 2;
      m_pres = fpmul(m_op1, m_op2);
      m_act  = 1'b1;
    end
    if (m_acked >= 0 && drop_on_ack[m_acked])
      s_req[m_acked] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clr_logs();
    ack_q.delete();
    ackres_q.delete();
    ackerr_q.delete();
    ackcyc_q.delete();
    rdy_n = 0;
  endtask

  task automatic run_acks(input int n, input int bound);
    int base;
    int k;
    base = ack_q.size();
    k = 0;
    while (ack_q.size() - base < n && k < bound) begin
      step();
      k++;
    end
    cmp("acks_seen", 32'(ack_q.size() - base), 32'(n));
  endtask

  task automatic wait_grant();
    int k;
    k = 0;
    while (!m_act && k < 20) begin
      step();
      k++;
    end
  endtask

  task automatic drain();
    int k;
    s_req = '0;
    k = 0;
    while (m_act && k < 100) begin
      step();
      k++;
    end
    step();
  endtask

  task automatic do_reset(input int n);
    s_rst = 1'b1;
    repeat (n) step();
    s_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      s_op1[i] = '0;
      s_op2[i] = '0;
      drop_on_ack[i] = 1'b1;
    end
    mif.mul_done = 1'b0;
    mif.mul_res  = '0;

    cmp("pin_2x3", fpmul(32'h40000000, 32'h40400000),
        32'h40C00000);
    cmp("pin_1p5sq", fpmul(32'h3FC00000, 32'h3FC00000),
        32'h40100000);

    do_reset(3);

    // single request
    clr_logs();
    s_op1[0] = 32'h40000000;
    s_op2[0] = 32'h40400000;
    s_lat = 3;
    s_req = 4'b0001;
    run_acks(1, 50);
    cmp("t1_who", 32'(ack_at(0)), 32'd0);
    cmp("t1_res", res_at(0), 32'h40C00000);
    cmp("t1_err", 32'(err_at(0)), 32'd0);
    drain();
    cmp("t1_ready_n", 32'(rdy_n), 32'd1);

    // all four at once, from ptr 0
    do_reset(2);
    clr_logs();
    s_op1[0] = 32'h40000000; s_op2[0] = 32'h40400000;
    s_op1[1] = 32'h40400000; s_op2[1] = 32'h3F000000;
    s_op1[2] = 32'h3FC00000; s_op2[2] = 32'h3FC00000;
    s_op1[3] = 32'hC0800000; s_op2[3] = 32'h40200000;
    s_lat = 1;
    s_req = 4'b1111;
    run_acks(4, 100);
    for (int i = 0; i < 4; i++)
      cmp("t2_order", 32'(ack_at(i)), 32'(i));
    cmp("t2_res0", res_at(0), 32'h40C00000);
    cmp("t2_res1", res_at(1), 32'h3FC00000);
    cmp("t2_res2", res_at(2), 32'h40100000);
    cmp("t2_res3", res_at(3), 32'hC1200000);
    drain();
    cmp("t2_ready_n", 32'(rdy_n), 32'd4);

    // fairness: 0 holds, 2 joins after first grant
    clr_logs();
    drop_on_ack[0] = 1'b0;
    s_lat = 4;
    s_req = 4'b0001;
    wait_grant();
    s_req[2] = 1'b1;
    run_acks(3, 100);
    cmp("t3_a", 32'(ack_at(0)), 32'd0);
    cmp("t3_b", 32'(ack_at(1)), 32'd2);
    cmp("t3_c", 32'(ack_at(2)), 32'd0);
    drop_on_ack[0] = 1'b1;
    drain();

    // watchdog, then a done on the very last WAIT cycle
    clr_logs();
    s_lat = 0;
    s_req = 4'b0010;
    run_acks(1, 80);
    cmp("t4_who", 32'(ack_at(0)), 32'd1);
    cmp("t4_err", 32'(err_at(0)), 32'd1);
    cmp("t4_res", res_at(0), 32'h7FC00000);
    cmp("t4_span", 32'((ackcyc_q.size() > 0 ?
        ackcyc_q[0] : 0) - rdy_cyc), 32'd32);
    s_lat = TMO;
    s_req = 4'b0100;
    run_acks(1, 80);
    cmp("t4_next_who", 32'(ack_at(1)), 32'd2);
    cmp("t4_next_err", 32'(err_at(1)), 32'd0);
    cmp("t4_next_res", res_at(1), 32'h40100000);
    drain();

    // operand change and req drop after grant
    clr_logs();
    s_op1[1] = 32'h40000000;
    s_op2[1] = 32'h40400000;
    s_lat = 2;
    s_req = 4'b0010;
    wait_grant();
    s_op1[1] = 32'h41000000;
    s_req[1] = 1'b0;
    step();
    cmp("t5_op1", rdy_op1, 32'h40000000);
    run_acks(1, 30);
    cmp("t5_who", 32'(ack_at(0)), 32'd1);
    cmp("t5_res", res_at(0), 32'h40C00000);
    drain();

    // reset mid-WAIT with ptr at 2
    clr_logs();
    s_lat = 0;
    s_req = 4'b0100;
    wait_grant();
    repeat (6) step();
    do_reset(1);
    cmp("t6_no_ack", 32'(ack_q.size()), 32'd0);
    s_lat = 2;
    s_req = 4'b0110;
    run_acks(2, 100);
    cmp("t6_first", 32'(ack_at(0)), 32'd1);
    cmp("t6_second", 32'(ack_at(1)), 32'd2);
    cmp("t6_err", 32'(err_at(1)), 32'd0);
    drain();

    // randomized traffic
    for (int i = 0; i < N; i++) drop_on_ack[i] = 1'b0;
    spur_en = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < N; k++) begin
        if (m_acked == k) begin
          if ($urandom_range(0, 1) == 0) s_req[k] = 1'b0;
        end else if (m_act && m_win == k) begin
          if ($urandom_range(0, 3) == 0) s_op1[k] = rand_fp();
          if ($urandom_range(0, 7) == 0) s_req[k] = 1'b0;
        end else if (s_req[k]) begin
          if ($urandom_range(0, 19) == 0) s_req[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          s_req[k] = 1'b1;
          s_op1[k] = rand_fp();
          s_op2[k] = rand_fp();
        end
      end
      case ($urandom_range(0, 9))
        0:       s_lat = 0;
        1:       s_lat = TMO;
        default: s_lat = int'($urandom_range(1, 6));
      endcase
      s_rst = ($urandom_range(0, 399) == 0);
      step();
    end
    s_rst = 1'b0;
    spur_en = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
